// File: rtl/sdram_req_arbiter.sv
// Round-robin arbiter sharing one SDRAM command sequencer among NUM_REQ clients.
// Optional watchdog compiled in with `define SDRAM_ARB_TIMEOUT_EN.
module sdram_req_arbiter #(
   parameter int NUM_REQ        = 2,
   parameter int ADDR_W         = 22,
   parameter int DATA_W         = 16,
   parameter int TIMEOUT_CYCLES = 1023
) (
   input  logic                      CLK,
   input  logic                      RESET,
   input  logic [NUM_REQ-1:0]        req_valid,
   input  logic [NUM_REQ-1:0]        req_we,
   input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
   input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
   output logic [NUM_REQ-1:0]        req_done,
   output logic [DATA_W-1:0]         req_rdata,
   input  logic [4:0]                ctrl_state,
   input  logic [DATA_W-1:0]         ctrl_rdata,
   output logic                      rd_enable,
   output logic                      wr_enable,
   output logic [ADDR_W-1:0]         mem_addr,
   output logic [DATA_W-1:0]         mem_wdata,
   output logic [NUM_REQ-1:0]        grant,
   output logic                      busy,
   output logic                      timeout_err,
   output logic [1:0]                arb_state
);

   // Handshake: a client raises req_valid and holds it (with stable fields) until
   // its one-cycle req_done; the arbiter latches the fields at grant, so anything
   // the client does afterwards, including dropping req_valid, is ignored.

   typedef enum logic [1:0] {A_IDLE, A_ISSUE, A_BUSY, A_DONE} arb_state_t;

   localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam logic [PTR_W:0] NUM_REQ_C = (PTR_W+1)'(NUM_REQ);

   arb_state_t       state, state_nxt;
   logic [PTR_W-1:0] rr_ptr;
   logic [PTR_W-1:0] win_idx;
   logic [PTR_W:0]   cand;
   logic             win_found;
   logic             we_lat, we_nxt;
   logic             tmo_hit;

   assign arb_state = state;

   // First requester at or above rr_ptr, wrapping modulo NUM_REQ.
   always_comb begin
      win_found = 1'b0;
      win_idx   = '0;
      cand      = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         cand = {1'b0, rr_ptr} + (PTR_W+1)'(k);
         if (cand >= NUM_REQ_C)
            cand = cand - NUM_REQ_C;
         if (!win_found && req_valid[cand[PTR_W-1:0]]) begin
            win_found = 1'b1;
            win_idx   = cand[PTR_W-1:0];
         end
      end
   end

   always_comb begin
      state_nxt = state;
      we_nxt    = we_lat;
      case (state)
         A_IDLE: begin
            if (win_found) begin
               state_nxt = A_ISSUE;
               we_nxt    = req_we[win_idx];
            end
         end
         A_ISSUE: if (ctrl_state[4])        state_nxt = A_BUSY;
         A_BUSY:  if (ctrl_state == 5'b0)   state_nxt = A_DONE;
         A_DONE:                            state_nxt = A_IDLE;
         default:                           state_nxt = A_IDLE;
      endcase
      if (tmo_hit)
         state_nxt = A_DONE;
   end

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET)
         state <= A_IDLE;
      else
         state <= state_nxt;
   end

   // Outputs are registered from the next state so they line up with the state register.
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         we_lat    <= 1'b0;
         rd_enable <= 1'b0;
         wr_enable <= 1'b0;
         busy      <= 1'b0;
         req_done  <= '0;
         grant     <= '0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         req_rdata <= '0;
         rr_ptr    <= '0;
      end else begin
         we_lat    <= we_nxt;
         rd_enable <= (state_nxt == A_ISSUE) && !we_nxt;
         wr_enable <= (state_nxt == A_ISSUE) &&  we_nxt;
         busy      <= (state_nxt != A_IDLE);
         req_done  <= (state_nxt == A_DONE) ? grant : '0;
         if (state == A_IDLE && win_found) begin
            grant     <= NUM_REQ'(1) << win_idx;
            mem_addr  <= req_addr[win_idx*ADDR_W +: ADDR_W];
            mem_wdata <= req_wdata[win_idx*DATA_W +: DATA_W];
            if (win_idx == PTR_W'(NUM_REQ-1))
               rr_ptr <= '0;
            else
               rr_ptr <= win_idx + 1'b1;
         end else if (state == A_DONE) begin
            grant <= '0;
         end
         if (tmo_hit)
            req_rdata <= '0;
         else if (state == A_BUSY && !we_lat && ctrl_state == 5'b10100)
            req_rdata <= ctrl_rdata;
      end
   end

`ifdef SDRAM_ARB_TIMEOUT_EN
   logic [9:0] tmo_cnt;
   logic       tmo_flag;

   // tmo_cnt holds the number of completed cycles since entering A_ISSUE.
   assign tmo_hit     = (state == A_ISSUE || state == A_BUSY) &&
                        (tmo_cnt == 10'(TIMEOUT_CYCLES-1));
   assign timeout_err = tmo_flag;

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         tmo_cnt  <= '0;
         tmo_flag <= 1'b0;
      end else begin
         if (state == A_IDLE && win_found)
            tmo_cnt <= '0;
         else if (state == A_ISSUE || state == A_BUSY)
            tmo_cnt <= tmo_cnt + 10'd1;
         if (tmo_hit)
            tmo_flag <= 1'b1;
      end
   end
`else
   assign tmo_hit     = 1'b0;
   assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_sdram_req_arbiter.sv
// Directed bench for sdram_req_arbiter: transaction table plus hand-written corner sequences.
module tb_sdram_req_arbiter;

  localparam int NR = 2;
  localparam int AW = 22;
  localparam int DW = 16;
  localparam int EW = 1 + NR + DW;

  logic           CLK;
  logic           RESET;
  logic [NR-1:0]  req_valid;
  logic [NR-1:0]  req_we;
  logic [NR*AW-1:0] req_addr;
  logic [NR*DW-1:0] req_wdata;
  logic [NR-1:0]  req_done;
  logic [DW-1:0]  req_rdata;
  logic [4:0]     ctrl_state;
  logic [DW-1:0]  ctrl_rdata;
  logic           rd_enable;
  logic           wr_enable;
  logic [AW-1:0]  mem_addr;
  logic [DW-1:0]  mem_wdata;
  logic [NR-1:0]  grant;
  logic           busy;
  logic           timeout_err;
  logic [1:0]     arb_state;

  int n_checks = 0;
  int n_fail   = 0;
  logic [EW-1:0] exp_q[$];

  sdram_req_arbiter #(
    .NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(20)
  ) dut (
    .CLK(CLK), .RESET(RESET),
    .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_done(req_done), .req_rdata(req_rdata),
    .ctrl_state(ctrl_state), .ctrl_rdata(ctrl_rdata),
    .rd_enable(rd_enable), .wr_enable(wr_enable),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .grant(grant), .busy(busy), .timeout_err(timeout_err), .arb_state(arb_state)
  );

  // clock / reset
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // driver tasks
  task automatic wait_en(input int max_c, output int lat);
    lat = 0;
    do begin
      tick();
      lat++;
    end while (!(rd_enable || wr_enable) && lat < max_c);
  endtask

  // Sequencer model: optional refresh detour, then the read or write path back to IDLE.
  task automatic seq_walk(input bit is_read, input int n_ref, input logic [DW-1:0] rd);
    for (int r = 0; r < n_ref; r++) begin
      ctrl_state = 5'(1 + (r % 4));
      tick();
      chk("refresh_hold", {31'd0, rd_enable | wr_enable}, 32'd1);
    end
    ctrl_state = is_read ? 5'b10000 : 5'b11000;
    ctrl_rdata = 16'hDEAD;
    tick();
    chk("enable_drop", {31'd0, rd_enable | wr_enable}, 32'd0);
    for (int s = 1; s < 4; s++) begin
      ctrl_state = (is_read ? 5'b10000 : 5'b11000) | 5'(s);
      tick();
    end
    if (is_read) begin
      ctrl_state = 5'b10100;
      ctrl_rdata = rd;
      tick();
    end
    ctrl_state = 5'b00000;
    ctrl_rdata = 16'hDEAD;
    tick();
  endtask

  // scoreboard: done pulses checked against the expected queue
  always @(negedge CLK) begin
    if (RESET === 1'b1) begin
      if (rd_enable || wr_enable) begin
        chk("enable_exclusive", {31'd0, rd_enable & wr_enable}, 32'd0);
        chk("enable_in_issue", {30'd0, arb_state}, 32'd1);
      end
      if (req_done != '0) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_done", {30'd0, req_done}, 32'd0);
        end else begin
          logic [EW-1:0] e;
          e = exp_q.pop_front();
          chk("done_onehot", {30'd0, req_done}, {30'd0, e[DW +: NR]});
          if (e[EW-1])
            chk("done_rdata", {16'd0, req_rdata}, {16'd0, e[DW-1:0]});
        end
      end
    end
  end

  typedef struct {
    logic [NR-1:0] valid;
    logic [NR-1:0] we;
    logic [AW-1:0] a0;
    logic [AW-1:0] a1;
    logic [DW-1:0] wd0;
    logic [DW-1:0] wd1;
    logic [DW-1:0] rdata;
    int            n_ref;
    int            lat;
    logic [NR-1:0] exp_grant;
    logic          exp_rd;
    logic [AW-1:0] exp_addr;
    logic [DW-1:0] exp_wdata;
  } vec_t;

  vec_t vecs[11];

  initial begin
    int lat;
    logic flag;

    vecs[0]  = '{2'b01, 2'b00, 22'h000123, 22'h000000, 16'h0000, 16'h0000, 16'hBEEF, 0, 1, 2'b01, 1'b1, 22'h000123, 16'h0000};
    vecs[1]  = '{2'b10, 2'b00, 22'h000123, 22'h2AAAAA, 16'h0000, 16'h0000, 16'h1234, 0, 2, 2'b10, 1'b1, 22'h2AAAAA, 16'h0000};
    vecs[2]  = '{2'b11, 2'b11, 22'h000100, 22'h000200, 16'h1111, 16'h2222, 16'h0000, 0, 2, 2'b01, 1'b0, 22'h000100, 16'h1111};
    vecs[3]  = '{2'b11, 2'b11, 22'h000100, 22'h000200, 16'h1111, 16'h2222, 16'h0000, 0, 2, 2'b10, 1'b0, 22'h000200, 16'h2222};
    vecs[4]  = '{2'b11, 2'b11, 22'h000100, 22'h000200, 16'h1111, 16'h2222, 16'h0000, 0, 2, 2'b01, 1'b0, 22'h000100, 16'h1111};
    vecs[5]  = '{2'b11, 2'b11, 22'h000100, 22'h000200, 16'h1111, 16'h2222, 16'h0000, 0, 2, 2'b10, 1'b0, 22'h000200, 16'h2222};
    vecs[6]  = '{2'b01, 2'b01, 22'h3FFFFF, 22'h000000, 16'hA5A5, 16'h0000, 16'h0000, 5, 2, 2'b01, 1'b0, 22'h3FFFFF, 16'hA5A5};
    vecs[7]  = '{2'b11, 2'b10, 22'h000042, 22'h155555, 16'h0000, 16'hC3C3, 16'h0000, 0, 2, 2'b10, 1'b0, 22'h155555, 16'hC3C3};
    vecs[8]  = '{2'b10, 2'b00, 22'h000000, 22'h000777, 16'h0000, 16'h0000, 16'h0F0F, 0, 2, 2'b10, 1'b1, 22'h000777, 16'h0000};
    vecs[9]  = '{2'b01, 2'b00, 22'h001000, 22'h000000, 16'h0000, 16'h0000, 16'h8001, 0, 2, 2'b01, 1'b1, 22'h001000, 16'h0000};
    vecs[10] = '{2'b01, 2'b00, 22'h001001, 22'h000000, 16'h0000, 16'h0000, 16'h7FFE, 0, 2, 2'b01, 1'b1, 22'h001001, 16'h0000};

    RESET = 1'b0;
    req_valid = '0; req_we = '0; req_addr = '0; req_wdata = '0;
    ctrl_state = 5'b0; ctrl_rdata = '0;
    repeat (3) tick();
    chk("rst_grant", {30'd0, grant}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_enables", {30'd0, rd_enable, wr_enable}, 32'd0);
    chk("rst_done", {30'd0, req_done}, 32'd0);
    chk("rst_data", {mem_addr[15:0], req_rdata | mem_wdata}, 32'd0);
    chk("rst_timeout", {31'd0, timeout_err}, 32'd0);
    RESET = 1'b1;
    tick();
    chk("idle_no_req", {31'd0, busy}, 32'd0);

    // table: arbitration, latching and data paths
    for (int i = 0; i < 11; i++) begin
      req_valid = vecs[i].valid;
      req_we    = vecs[i].we;
      req_addr  = {vecs[i].a1, vecs[i].a0};
      req_wdata = {vecs[i].wd1, vecs[i].wd0};
      wait_en(6, lat);
      chk($sformatf("v%0d_latency", i), lat, vecs[i].lat);
      chk($sformatf("v%0d_grant", i), {30'd0, grant}, {30'd0, vecs[i].exp_grant});
      chk($sformatf("v%0d_rd_en", i), {31'd0, rd_enable}, {31'd0, vecs[i].exp_rd});
      chk($sformatf("v%0d_wr_en", i), {31'd0, wr_enable}, {31'd0, ~vecs[i].exp_rd});
      chk($sformatf("v%0d_addr", i), {10'd0, mem_addr}, {10'd0, vecs[i].exp_addr});
      chk($sformatf("v%0d_wdata", i), {16'd0, mem_wdata}, {16'd0, vecs[i].exp_wdata});
      chk($sformatf("v%0d_busy", i), {31'd0, busy}, 32'd1);
      exp_q.push_back({vecs[i].exp_rd, vecs[i].exp_grant, vecs[i].rdata});
      seq_walk(vecs[i].exp_rd, vecs[i].n_ref, vecs[i].rdata);
      chk($sformatf("v%0d_done", i), {30'd0, req_done}, {30'd0, vecs[i].exp_grant});
    end

    // granted client changes its address and drops valid mid-transaction
    req_valid = 2'b01; req_we = 2'b00;
    req_addr = {22'h0, 22'h0ABCDE};
    wait_en(6, lat);
    chk("mid_latency", lat, 2);
    exp_q.push_back({1'b1, 2'b01, 16'h5A5A});
    ctrl_state = 5'b10000;
    tick();
    req_addr[AW-1:0] = 22'h3C3C3C;
    req_valid = 2'b00;
    req_we = 2'b01;
    ctrl_state = 5'b10001;
    tick();
    chk("mid_addr_held", {10'd0, mem_addr}, {10'd0, 22'h0ABCDE});
    chk("mid_busy", {31'd0, busy}, 32'd1);
    ctrl_state = 5'b10100; ctrl_rdata = 16'h5A5A;
    tick();
    ctrl_state = 5'b00000; ctrl_rdata = 16'hDEAD;
    tick();
    chk("mid_done", {30'd0, req_done}, 32'd1);
    tick();
    chk("mid_grant_clear", {30'd0, grant}, 32'd0);
    chk("mid_idle", {31'd0, busy}, 32'd0);

    // asynchronous reset while in A_BUSY
    req_valid = 2'b01; req_we = 2'b00; req_addr = {22'h0, 22'h111111};
    wait_en(6, lat);
    chk("rstb_latency", lat, 1);
    ctrl_state = 5'b10000;
    tick();
    ctrl_state = 5'b10001;
    tick();
    chk("rstb_in_busy", {30'd0, arb_state}, 32'd2);
    #3 RESET = 1'b0;
    #1;
    chk("rstb_grant", {30'd0, grant}, 32'd0);
    chk("rstb_busy_en", {29'd0, busy, rd_enable, wr_enable}, 32'd0);
    chk("rstb_addr", {10'd0, mem_addr}, 32'd0);
    chk("rstb_rdata", {16'd0, req_rdata}, 32'd0);
    chk("rstb_done", {30'd0, req_done}, 32'd0);
    ctrl_state = 5'b00000; req_valid = 2'b00;
    tick();
    #3 RESET = 1'b1;
    tick();
    chk("rstb_post_idle", {30'd0, grant}, 32'd0);
    req_valid = 2'b11; req_we = 2'b00; req_addr = {22'h000654, 22'h000321};
    wait_en(6, lat);
    chk("rstb_rr_grant", {30'd0, grant}, 32'd1);
    chk("rstb_rr_addr", {10'd0, mem_addr}, {10'd0, 22'h000321});
    exp_q.push_back({1'b1, 2'b01, 16'h4321});
    seq_walk(1'b1, 0, 16'h4321);

    // sequencer never leaves IDLE after the issue
    req_valid = 2'b10; req_we = 2'b10; req_wdata = {16'hFACE, 16'h0000};
    wait_en(6, lat);
    chk("tmo_grant", {30'd0, grant}, 32'd2);
    ctrl_state = 5'b00000;
`ifdef SDRAM_ARB_TIMEOUT_EN
    exp_q.push_back({1'b1, 2'b10, 16'h0000});
    flag = 1'b0;
    for (int c = 0; c < 19; c++) begin
      tick();
      if (timeout_err !== 1'b0 || wr_enable !== 1'b1) flag = 1'b1;
    end
    chk("tmo_not_early", {31'd0, flag}, 32'd0);
    tick();
    chk("tmo_set", {31'd0, timeout_err}, 32'd1);
    chk("tmo_enable_drop", {31'd0, wr_enable}, 32'd0);
    chk("tmo_done", {30'd0, req_done}, 32'd2);
    chk("tmo_rdata", {16'd0, req_rdata}, 32'd0);
    req_valid = 2'b00;
    repeat (3) tick();
    chk("tmo_sticky", {31'd0, timeout_err}, 32'd1);
`else
    flag = 1'b0;
    for (int c = 0; c < 25; c++) begin
      tick();
      if (timeout_err !== 1'b0 || wr_enable !== 1'b1 || arb_state !== 2'd1) flag = 1'b1;
    end
    chk("no_tmo_hold", {31'd0, flag}, 32'd0);
    exp_q.push_back({1'b0, 2'b10, 16'h0000});
    seq_walk(1'b0, 0, 16'h0000);
    chk("no_tmo_done", {30'd0, req_done}, 32'd2);
    req_valid = 2'b00;
    repeat (3) tick();
    chk("no_tmo_err", {31'd0, timeout_err}, 32'd0);
`endif

    // final report
    repeat (2) tick();
    chk("scoreboard_empty", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
